axi_stream_pkt_arbiter: RTL and testbench



---
 rtl/axi_stream_pkt_arbiter_pkg.sv | 7 +
 rtl/axi_stream_pkt_arbiter_rr_pick.sv | 32 +++
 rtl/axi_stream_pkt_arbiter.sv | 124 ++++++++++++
 tb/tb_axi_stream_pkt_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkt_arbiter_pkg.sv
// stream_arb_pkg: arbiter state encoding and source index assignments
package stream_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_PASS, ARB_DISCARD} arb_state_t;
    localparam int SRC_RUN = 0;
    localparam int SRC_ADC = 1;
    localparam int SRC_TI  = 2;
endpackage

// File: rtl/axi_stream_pkt_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request after 'last' wrapping modulo NUM_SRC
//   req   : per-source request vector
//   last  : index granted most recently
//   found : any request present
//   idx   : chosen source index
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);
    logic [SEL_W-1:0] w_j;

    // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_j   = '0;
        for (int o = NUM_SRC; o >= 1; o--) begin
            w_j = SEL_W'((int'(last) + o) % NUM_SRC);
            if (req[w_j]) begin
                found = 1'b1;
                idx   = w_j;
            end
        end
    end
endmodule

// File: rtl/axi_stream_pkt_arbiter.sv
// axi_stream_pkt_arbiter: packet-atomic round-robin merge of NUM_SRC AXI-Stream sources with beat watchdog
//   clk, rst                     : clock, async active-high reset
//   ena, src_mask                : gate new grants / per-source grant enable
//   clear_counters               : sync clear of statistics
//   in_tdata/tvalid/tlast/tready : per-source streams (flattened, source 0 in LSBs)
//   out_tdata/tvalid/tlast/tid/tready : merged stream, tid = granted source
//   pkt_count, trunc_count       : completed packets per source, watchdog truncations
//   busy                         : a packet is being passed or discarded
module axi_stream_pkt_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_SRC       = 3,
    parameter int DATA_WIDTH    = 64,
    parameter int MAX_PKT_BEATS = 1024,
    parameter int CNT_WIDTH     = 32,
    parameter int SEL_W         = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic [NUM_SRC-1:0]            src_mask,
    input  logic                          clear_counters,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] in_tdata,
    input  logic [NUM_SRC-1:0]            in_tvalid,
    input  logic [NUM_SRC-1:0]            in_tlast,
    output logic [NUM_SRC-1:0]            in_tready,
    output logic [DATA_WIDTH-1:0]         out_tdata,
    output logic                          out_tvalid,
    output logic                          out_tlast,
    output logic [SEL_W-1:0]              out_tid,
    input  logic                          out_tready,
    output logic [NUM_SRC*CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]          trunc_count,
    output logic                          busy
);
    localparam int BW = $clog2(MAX_PKT_BEATS);

    arb_state_t            r_state;
    logic [SEL_W-1:0]      r_grant;
    logic [SEL_W-1:0]      r_last_grant;
    logic [BW-1:0]         r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_pkt [NUM_SRC];
    logic [CNT_WIDTH-1:0]  r_trunc;
    logic [DATA_WIDTH-1:0] w_data [NUM_SRC];
    logic [NUM_SRC-1:0]    w_req;
    logic [SEL_W-1:0]      w_idx;
    logic                  w_found;
    logic                  w_src_last;
    logic                  w_limit;
    logic                  w_acc;
    logic                  w_end;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign w_data[i] = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = r_pkt[i];
    end

    assign w_req       = ena ? (in_tvalid & src_mask) : '0;
    assign trunc_count = r_trunc;

    rr_pick #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_pick (
        .req   (w_req),
        .last  (r_last_grant),
        .found (w_found),
        .idx   (w_idx)
    );

    // Zero-latency data path: everything below is steered by the registered grant only.
    always_comb begin
        w_src_last = in_tlast[r_grant];
        w_limit    = r_beat_cnt == BW'(MAX_PKT_BEATS - 1);
        out_tvalid = (r_state == ARB_PASS) && in_tvalid[r_grant];
        out_tdata  = w_data[r_grant];
        out_tlast  = out_tvalid && (w_src_last || w_limit);
        out_tid    = r_grant;
        w_acc      = out_tvalid && out_tready;
        w_end      = w_acc && (w_src_last || w_limit);
        busy       = r_state != ARB_IDLE;
        in_tready  = '0;
        in_tready[r_grant] = (r_state == ARB_PASS) ? out_tready : (r_state == ARB_DISCARD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_grant      <= '0;
            r_last_grant <= SEL_W'(NUM_SRC - 1);
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: if (w_found) begin
                    r_grant      <= w_idx;
                    r_last_grant <= w_idx;
                    r_beat_cnt   <= '0;
                    r_state      <= ARB_PASS;
                end
                ARB_PASS: if (w_acc) begin
                    r_beat_cnt <= r_beat_cnt + BW'(1);
                    if (w_src_last)
                        r_state <= ARB_IDLE;
                    else if (w_limit)
                        r_state <= ARB_DISCARD;
                end
                ARB_DISCARD: if (in_tvalid[r_grant] && w_src_last)
                    r_state <= ARB_IDLE;
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear_counters) begin
            for (int s = 0; s < NUM_SRC; s++)
                r_pkt[s] <= '0;
            r_trunc <= '0;
        end else begin
            if (w_end)
                r_pkt[r_grant] <= r_pkt[r_grant] + CNT_WIDTH'(1);
            // Ending without the source's tlast means the watchdog cut the packet.
            if (w_end && !w_src_last)
                r_trunc <= r_trunc + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_axi_stream_pkt_arbiter.sv
// tb_axi_stream_pkt_arbiter: directed scoreboard bench for the packet arbiter
module tb_axi_stream_pkt_arbiter;
    import stream_arb_pkg::*;

    localparam int NS = 3, DW = 64, CW = 32, MAXB = 16;

    typedef struct {
        logic [1:0]  tid;
        logic [63:0] d;
        logic        l;
    } beat_t;

    logic              clk = 0, rst = 1, ena = 1, clear_counters = 0, out_tready = 1;
    logic [NS-1:0]     src_mask = '1, in_tvalid = '0, in_tlast = '0, in_tready, src_on = '1, fire;
    logic [NS*DW-1:0]  in_tdata = '0;
    logic [DW-1:0]     out_tdata;
    logic              out_tvalid, out_tlast, busy;
    logic [1:0]        out_tid;
    logic [NS*CW-1:0]  pkt_count;
    logic [CW-1:0]     trunc_count;

    beat_t srcq [NS][$];
    beat_t exp_q [$];
    int    checks = 0, errors = 0, last_run = 0, pid = 0;
    bit    toggle_rdy = 0, clr_on_last = 0;

    always #5 clk = ~clk;

    axi_stream_pkt_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_PKT_BEATS(MAXB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .src_mask(src_mask), .clear_counters(clear_counters),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tid(out_tid),
        .out_tready(out_tready), .pkt_count(pkt_count), .trunc_count(trunc_count), .busy(busy)
    );

    function automatic logic [63:0] mk(input int s, input int id, input int b);
        return {8'(s), 24'(id), 32'(b)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic load(input int s, input int id, input int n);
        beat_t x;
        for (int b = 1; b <= n; b++) begin
            x.tid = 2'(s); x.d = mk(s, id, b); x.l = (b == n);
            srcq[s].push_back(x);
        end
    endtask

    task automatic expect_beats(input int s, input int id, input int from, input int to, input int last_at);
        beat_t x;
        for (int b = from; b <= to; b++) begin
            x.tid = 2'(s); x.d = mk(s, id, b); x.l = (b == last_at);
            exp_q.push_back(x);
        end
    endtask

    task automatic drive();
        for (int s = 0; s < NS; s++) begin
            in_tvalid[s] = src_on[s] && srcq[s].size() > 0;
            in_tlast[s]  = 1'b0;
            in_tdata[s*DW +: DW] = '0;
            if (srcq[s].size() > 0) begin
                in_tlast[s] = srcq[s][0].l;
                in_tdata[s*DW +: DW] = srcq[s][0].d;
            end
        end
    endtask

    task automatic step();
        beat_t e;
        @(negedge clk);
        fire = in_tvalid & in_tready;
        if (busy)
            check("rdy_only_grant", 64'(in_tready & ~(3'b001 << out_tid)), 64'(0));
        if (out_tvalid && out_tready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_beat tid=%0d data=%0h want=none", out_tid, out_tdata);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("beat_tid", 64'(out_tid), 64'(e.tid));
                check("beat_data", out_tdata, e.d);
                check("beat_last", 64'(out_tlast), 64'(e.l));
            end
            if (clr_on_last && out_tlast) clear_counters = 1;
        end
        @(posedge clk);
        #1;
        clear_counters = 0;
        for (int s = 0; s < NS; s++)
            if (fire[s]) srcq[s].delete(0);
        if (toggle_rdy) out_tready = ~out_tready;
        drive();
    endtask

    task automatic run(input string tag, input int maxc);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < maxc) begin
            step();
            n++;
        end
        last_run = n;
        check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_counts(input string tag, input int c0, input int c1, input int c2, input int tr);
        check({tag, "_pkt0"}, 64'(pkt_count[0*CW +: CW]), 64'(c0));
        check({tag, "_pkt1"}, 64'(pkt_count[1*CW +: CW]), 64'(c1));
        check({tag, "_pkt2"}, 64'(pkt_count[2*CW +: CW]), 64'(c2));
        check({tag, "_trunc"}, 64'(trunc_count), 64'(tr));
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        drive();
        check("rst_tvalid", 64'(out_tvalid), 64'(0));
        check("rst_tlast", 64'(out_tlast), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_tid", 64'(out_tid), 64'(0));
        check("rst_tready", 64'(in_tready), 64'(0));
        check_counts("rst", 0, 0, 0, 0);

        // Round-robin fairness: 30 four-beat packets, 5 cycles each
        for (int r = 0; r < 10; r++)
            for (int s = 0; s < NS; s++) begin
                load(s, pid, 4);
                expect_beats(s, pid, 1, 4, 4);
                pid++;
            end
        drive();
        run("fair", 400);
        check("fair_cycles", 64'(last_run), 64'(150));
        check_counts("fair", 10, 10, 10, 0);

        // Atomicity under 50% backpressure; source 0 starts requesting mid-packet
        src_on = 3'b010;
        load(SRC_ADC, pid, 8);  expect_beats(SRC_ADC, pid, 1, 8, 8); pid++;
        load(SRC_RUN, pid, 2);  expect_beats(SRC_RUN, pid, 1, 2, 2); pid++;
        toggle_rdy = 1;
        drive();
        repeat (4) step();
        src_on = 3'b111;
        drive();
        run("atom", 100);
        toggle_rdy = 0;
        out_tready = 1;
        drive();

        // Masking: source 1 requests but never gets a grant
        src_mask = 3'b101;
        load(SRC_TI, pid, 2);  expect_beats(SRC_TI, pid, 1, 2, 2);  pid++;
        load(SRC_RUN, pid, 2); expect_beats(SRC_RUN, pid, 1, 2, 2); pid++;
        load(SRC_TI, pid, 2);  expect_beats(SRC_TI, pid, 1, 2, 2);  pid++;
        load(SRC_RUN, pid, 2); expect_beats(SRC_RUN, pid, 1, 2, 2); pid++;
        n = pid;
        load(SRC_ADC, n, 4); pid++;
        drive();
        run("mask", 100);
        repeat (6) step();
        check("mask_src1_left", 64'(srcq[SRC_ADC].size()), 64'(4));

        // Enable dropped mid-packet: the packet finishes, nothing further is granted
        src_mask = 3'b111;
        expect_beats(SRC_ADC, n, 1, 4, 4);
        load(SRC_RUN, pid, 2);
        drive();
        repeat (2) step();
        ena = 0;
        run("ena", 50);
        repeat (8) step();
        check("ena_busy", 64'(busy), 64'(0));
        check("ena_src0_left", 64'(srcq[SRC_RUN].size()), 64'(2));
        ena = 1;
        expect_beats(SRC_RUN, pid, 1, 2, 2); pid++;
        run("ena_resume", 50);

        // Watchdog: 20-beat packet cut at 16, rest discarded
        clear_counters = 1;
        step();
        check_counts("clr", 0, 0, 0, 0);
        load(SRC_TI, pid, 20);
        expect_beats(SRC_TI, pid, 1, 16, 16); pid++;
        drive();
        run("wd", 100);
        n = 0;
        while (srcq[SRC_TI].size() > 0 && n < 20) begin
            step();
            n++;
        end
        check("wd_discarded", 64'(srcq[SRC_TI].size()), 64'(0));
        check("wd_busy", 64'(busy), 64'(0));
        check_counts("wd", 0, 0, 1, 1);

        // Reset on beat 3 of a 6-beat packet from source 1
        n = pid;
        load(SRC_ADC, n, 6);
        expect_beats(SRC_ADC, n, 1, 2, 6); pid++;
        drive();
        run("prerst", 50);
        check("prerst_tvalid", 64'(out_tvalid), 64'(1));
        check("prerst_tid", 64'(out_tid), 64'(1));
        #1 rst = 1;
        #1;
        check("midrst_tvalid", 64'(out_tvalid), 64'(0));
        check("midrst_tlast", 64'(out_tlast), 64'(0));
        check("midrst_tready", 64'(in_tready), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_tid", 64'(out_tid), 64'(0));
        #1 rst = 0;
        check_counts("postrst", 0, 0, 0, 0);
        load(SRC_RUN, pid, 3);
        expect_beats(SRC_RUN, pid, 1, 3, 3); pid++;
        expect_beats(SRC_ADC, n, 3, 6, 6);
        drive();
        run("postrst", 60);
        check_counts("postrst_done", 1, 1, 0, 0);

        // Clear collides with an accepted tlast
        load(SRC_TI, pid, 2);
        expect_beats(SRC_TI, pid, 1, 2, 2); pid++;
        clr_on_last = 1;
        drive();
        run("clr_coll", 50);
        clr_on_last = 0;
        check_counts("clr_coll", 0, 0, 0, 0);
        check("clr_coll_busy", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
